// File: rtl/spi_frame_sniffer.sv
// Passive SPI observer: rebuilds DATA_SIZE-bit MOSI/MISO words from synchronized bus
// lines and hands them to the control logic over valid/ready, with frame start/end flags.
module spi_frame_sniffer #(
   parameter int DATA_SIZE = 8,
   parameter int CPOL      = 0,
   parameter int CPHA      = 0,
   parameter int MSB_FIRST = 1,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 sclk_in,
   input  logic                 ss_in,
   input  logic                 mosi_in,
   input  logic                 miso_in,
   output logic [DATA_SIZE-1:0] mosi_data,
   output logic [DATA_SIZE-1:0] miso_data,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 overrun,
   output logic                 frame_active,
   output logic                 frame_start,
   output logic                 frame_end,
   output logic                 truncated,
   output logic [CNT_WIDTH-1:0] word_count
);

   localparam int BW = $clog2(DATA_SIZE);
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_SIZE - 1);
   localparam logic SCLK_IDLE = (CPOL != 0);

   // Handshake: a word pair is transferred on every cycle where data_valid && data_ready;
   // data_valid is held, and the data is stable, until that happens (barring overrun).

   logic [0:0]           state_q, state_d;
   logic                 sclk_prev_q, ss_prev_q;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_SIZE-1:0] mosi_sh_q, mosi_sh_d, miso_sh_q, miso_sh_d;
   logic [DATA_SIZE-1:0] mosi_data_q, mosi_data_d, miso_data_q, miso_data_d;
   logic                 valid_q, valid_d;
   logic                 overrun_q, overrun_d;
   logic                 start_q, start_d, end_q, end_d, trunc_q, trunc_d;
   logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
   logic                 sample_edge, ss_fall, ss_rise, word_done;

   assign sample_edge = (CPOL == CPHA) ? (~sclk_prev_q & sclk_in) : (sclk_prev_q & ~sclk_in);
   assign ss_fall     = ss_prev_q & ~ss_in;
   assign ss_rise     = ~ss_prev_q & ss_in;

   function automatic logic [DATA_SIZE-1:0] shift_in(input logic [DATA_SIZE-1:0] sh,
                                                     input logic b);
      if (MSB_FIRST != 0) shift_in = {sh[DATA_SIZE-2:0], b};
      else                shift_in = {b, sh[DATA_SIZE-1:1]};
   endfunction

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      mosi_sh_d   = mosi_sh_q;
      miso_sh_d   = miso_sh_q;
      mosi_data_d = mosi_data_q;
      miso_data_d = miso_data_q;
      valid_d     = valid_q;
      overrun_d   = overrun_q;
      wcnt_d      = wcnt_q;
      start_d     = 1'b0;
      end_d       = 1'b0;
      trunc_d     = 1'b0;
      word_done   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d   = ST_ACTIVE;
               start_d   = 1'b1;
               wcnt_d    = '0;
               bit_cnt_d = '0;
            end
         end
         default: begin
            // ss_rise takes priority over a coincident sample edge; partial word is dropped.
            if (ss_rise) begin
               state_d   = ST_IDLE;
               end_d     = 1'b1;
               trunc_d   = (bit_cnt_q != '0);
               bit_cnt_d = '0;
            end else if (sample_edge) begin
               mosi_sh_d = shift_in(mosi_sh_q, mosi_in);
               miso_sh_d = shift_in(miso_sh_q, miso_in);
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  word_done = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
      endcase

      if (valid_q && data_ready) valid_d = 1'b0;

      // A completing word wins over a same-cycle accept, so valid stays up with new data.
      if (word_done) begin
         mosi_data_d = mosi_sh_d;
         miso_data_d = miso_sh_d;
         valid_d     = 1'b1;
         if (valid_q && !data_ready) overrun_d = 1'b1;
         if (wcnt_q != {CNT_WIDTH{1'b1}}) wcnt_d = wcnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sclk_prev_q <= SCLK_IDLE;
         ss_prev_q   <= 1'b1;
         bit_cnt_q   <= '0;
         mosi_sh_q   <= '0;
         miso_sh_q   <= '0;
         mosi_data_q <= '0;
         miso_data_q <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         wcnt_q      <= '0;
         start_q     <= 1'b0;
         end_q       <= 1'b0;
         trunc_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_prev_q <= sclk_in;
         ss_prev_q   <= ss_in;
         bit_cnt_q   <= bit_cnt_d;
         mosi_sh_q   <= mosi_sh_d;
         miso_sh_q   <= miso_sh_d;
         mosi_data_q <= mosi_data_d;
         miso_data_q <= miso_data_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         wcnt_q      <= wcnt_d;
         start_q     <= start_d;
         end_q       <= end_d;
         trunc_q     <= trunc_d;
      end
   end

   assign mosi_data    = mosi_data_q;
   assign miso_data    = miso_data_q;
   assign data_valid   = valid_q;
   assign overrun      = overrun_q;
   assign frame_active = (state_q == ST_ACTIVE);
   assign frame_start  = start_q;
   assign frame_end    = end_q;
   assign truncated    = trunc_q;
   assign word_count   = wcnt_q;

endmodule

// File: tb/tb_spi_frame_sniffer.sv
// Scoreboard bench for spi_frame_sniffer: a mode-0 MSB-first instance driven through
// directed frames, plus a CPOL=1/CPHA=1 LSB-first instance for bit-order checks.
module tb_spi_frame_sniffer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT 0: mode 0, MSB first ----------------
   logic       sclk = 1'b0, ss = 1'b1, mosi = 1'b0, miso = 1'b0, ready = 1'b1;
   logic [7:0] mosi_data, miso_data;
   logic       data_valid, overrun, frame_active, frame_start, frame_end, truncated;
   logic [15:0] word_count;

   spi_frame_sniffer u0 (
      .sys_clk(clk), .rst(rst), .sclk_in(sclk), .ss_in(ss), .mosi_in(mosi), .miso_in(miso),
      .mosi_data(mosi_data), .miso_data(miso_data), .data_valid(data_valid),
      .data_ready(ready), .overrun(overrun), .frame_active(frame_active),
      .frame_start(frame_start), .frame_end(frame_end), .truncated(truncated),
      .word_count(word_count)
   );

   // ---------------- DUT 1: CPOL=1, CPHA=1, LSB first ----------------
   logic       sclk1 = 1'b1, ss1 = 1'b1, mosi1 = 1'b0, miso1 = 1'b0;
   logic [7:0] mosi_data1, miso_data1;
   logic       data_valid1, overrun1, frame_active1, frame_start1, frame_end1, truncated1;
   logic [15:0] word_count1;

   spi_frame_sniffer #(.CPOL(1), .CPHA(1), .MSB_FIRST(0)) u1 (
      .sys_clk(clk), .rst(rst), .sclk_in(sclk1), .ss_in(ss1), .mosi_in(mosi1), .miso_in(miso1),
      .mosi_data(mosi_data1), .miso_data(miso_data1), .data_valid(data_valid1),
      .data_ready(1'b1), .overrun(overrun1), .frame_active(frame_active1),
      .frame_start(frame_start1), .frame_end(frame_end1), .truncated(truncated1),
      .word_count(word_count1)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   int start_cnt = 0;
   logic [15:0] exp_q[$];   // {mosi, miso} per accepted word
   logic [16:0] ev_q[$];    // {truncated, word_count} per frame_end
   logic        u1_seen = 1'b0;
   logic [7:0]  u1_mosi = '0, u1_miso = '0;
   logic [15:0] u1_wc = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (data_valid && ready) begin
            if (exp_q.size() == 0) check("unexpected_word", {16'h0, mosi_data, miso_data}, 32'hFFFF_FFFF);
            else check("word", {16'h0, mosi_data, miso_data}, {16'h0, exp_q.pop_front()});
         end
         if (frame_end) begin
            if (ev_q.size() == 0) check("unexpected_frame_end", 32'h1, 32'h0);
            else check("frame_end trunc/wc", {15'h0, truncated, word_count}, {15'h0, ev_q.pop_front()});
            check("frame_active at end", {31'h0, frame_active}, 32'h0);
         end
         if (frame_start) begin
            start_cnt++;
            check("word_count at start", {16'h0, word_count}, 32'h0);
            check("frame_active at start", {31'h0, frame_active}, 32'h1);
         end
         if (data_valid1) begin
            u1_seen = 1'b1;
            u1_mosi = mosi_data1;
            u1_miso = miso_data1;
            u1_wc   = word_count1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit0(input logic m, input logic s);
      mosi = m; miso = s;
      wait_clk(3);
      sclk = 1'b1;
      wait_clk(3);
      sclk = 1'b0;
   endtask

   task automatic send_byte0(input logic [7:0] m, input logic [7:0] s);
      for (int i = 7; i >= 0; i--) send_bit0(m[i], s[i]);
   endtask

   task automatic ss_low0();
      ss = 1'b0;
      wait_clk(3);
   endtask

   task automatic ss_high0();
      wait_clk(3);
      ss = 1'b1;
      wait_clk(4);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " mosi_data"}, {24'h0, mosi_data}, 32'h0);
      check({tag, " miso_data"}, {24'h0, miso_data}, 32'h0);
      check({tag, " flags"}, {26'h0, data_valid, overrun, frame_active, frame_start, frame_end, truncated}, 32'h0);
      check({tag, " word_count"}, {16'h0, word_count}, 32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] lsb_bits;
      wait_clk(3);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      wait_clk(3);

      // Mode 0 single word
      exp_q.push_back({8'hA5, 8'h3C});
      ev_q.push_back({1'b0, 16'd1});
      ss_low0();
      send_byte0(8'hA5, 8'h3C);
      ss_high0();
      check("overrun after single", {31'h0, overrun}, 32'h0);

      // Three words back to back, consumer always ready
      exp_q.push_back({8'h01, 8'h10});
      exp_q.push_back({8'h02, 8'h20});
      exp_q.push_back({8'h03, 8'h30});
      ev_q.push_back({1'b0, 16'd3});
      ss_low0();
      send_byte0(8'h01, 8'h10);
      send_byte0(8'h02, 8'h20);
      send_byte0(8'h03, 8'h30);
      ss_high0();
      check("overrun after three", {31'h0, overrun}, 32'h0);
      check("word_count after three", {16'h0, word_count}, 32'd3);

      // Overrun: two words with consumer stalled; only the second survives
      ready = 1'b0;
      ev_q.push_back({1'b0, 16'd2});
      ss_low0();
      send_byte0(8'h11, 8'h22);
      send_byte0(8'h33, 8'h44);
      ss_high0();
      @(negedge clk);
      check("stalled valid", {31'h0, data_valid}, 32'h1);
      check("stalled mosi_data", {24'h0, mosi_data}, 32'h33);
      check("overrun set", {31'h0, overrun}, 32'h1);
      exp_q.push_back({8'h33, 8'h44});
      @(posedge clk); #1;
      ready = 1'b1;
      wait_clk(2);
      check("valid dropped after accept", {31'h0, data_valid}, 32'h0);
      check("overrun sticky", {31'h0, overrun}, 32'h1);

      // Truncated frame: 5 bits then ss rises
      ev_q.push_back({1'b1, 16'd0});
      ss_low0();
      for (int i = 0; i < 5; i++) send_bit0(1'b1, 1'b0);
      ss_high0();
      check("no valid after truncation", {31'h0, data_valid}, 32'h0);
      check("overrun still sticky", {31'h0, overrun}, 32'h1);

      // Reset mid-frame, then a clean frame
      ss_low0();
      for (int i = 0; i < 4; i++) send_bit0(1'b1, 1'b1);
      rst = 1'b1;
      wait_clk(2);
      @(negedge clk);
      check_reset_outputs("midframe reset");
      ss = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      wait_clk(3);
      exp_q.push_back({8'h5A, 8'hA5});
      ev_q.push_back({1'b0, 16'd1});
      ss_low0();
      send_byte0(8'h5A, 8'hA5);
      ss_high0();
      check("overrun cleared by reset", {31'h0, overrun}, 32'h0);

      // CPOL=1/CPHA=1 LSB-first instance: bits 1,0,0,... -> 0x01; MISO bits 0,1,0,... -> 0x02
      lsb_bits = 8'b0000_0001;
      ss1 = 1'b0;
      wait_clk(3);
      for (int i = 0; i < 8; i++) begin
         sclk1 = 1'b0;
         mosi1 = lsb_bits[i];
         miso1 = (i == 1);
         wait_clk(3);
         sclk1 = 1'b1;
         wait_clk(3);
      end
      ss1 = 1'b1;
      wait_clk(4);
      check("u1 valid seen", {31'h0, u1_seen}, 32'h1);
      check("u1 mosi_data", {24'h0, u1_mosi}, 32'h01);
      check("u1 miso_data", {24'h0, u1_miso}, 32'h02);
      check("u1 word_count", {16'h0, u1_wc}, 32'd1);

      wait_clk(4);
      check("frame starts", start_cnt, 32'd6);
      check("words left", exp_q.size(), 32'd0);
      check("frame ends left", ev_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
